fetch_sequencer: RTL

- Run-control FSM that sequences the program counter (ProgCtr) over one program execution.
- Holds the PC cleared while Start is high; releases fetch on the Start falling edge.
- Gates the PC advance and the absolute/relative branch enables with stall, condition flag and halt.
- Stops on a decoded halt instruction or a cycle-limit watchdog; exposes cycle and instruction counters for the bench and top level.

---
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Run-control sequencer for the program counter over one program execution.
// Handles arm/run/done sequencing, PC enables, counters and the cycle watchdog.
module fetch_sequencer #(
  parameter int                 CYC_W   = 16,
  parameter logic [CYC_W-1:0]   MAX_CYC = 16'hFFFF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt_i,
  input  logic             BranchAbs_i,
  input  logic             BranchRel_i,
  input  logic             ALU_flag,
  input  logic             Stall_i,
  output logic             PcClear_o,
  output logic             PcEn_o,
  output logic             BranchAbsEn,
  output logic             BranchRelEn,
  output logic             Busy,
  output logic             Done,
  output logic             Timeout,
  output logic [CYC_W-1:0] CycleCnt,
  output logic [CYC_W-1:0] InstrCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [CYC_W-1:0] ONE     = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] WD_LAST = MAX_CYC - ONE;
  localparam logic             WD_EN   = (MAX_CYC != '0);

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] ins_q, ins_d;
  logic             to_q, to_d;

  logic ret;
  logic halt_hit;
  logic wd_hit;

  assign ret      = !Stall_i;
  assign halt_hit = Halt_i & ret;
  assign wd_hit   = WD_EN & (cyc_q == WD_LAST);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    ins_d       = ins_q;
    to_d        = to_q;
    PcClear_o   = 1'b0;
    PcEn_o      = 1'b0;
    BranchAbsEn = 1'b0;
    BranchRelEn = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        PcClear_o = 1'b1;
        if (Start) state_d = ARM;
      end
      ARM: begin
        PcClear_o = 1'b1;
        if (!Start) state_d = RUN;
      end
      RUN: begin
        Busy  = 1'b1;
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + ONE;
        // Start rising while running aborts; suppress all enables
        if (Start) begin
          state_d = ARM;
        end else begin
          PcEn_o      = ret & !Halt_i;
          BranchAbsEn = PcEn_o & BranchAbs_i & ALU_flag;
          BranchRelEn = PcEn_o & BranchRel_i & ALU_flag & !BranchAbs_i;
          if (ret) ins_d = (&ins_q) ? ins_q : ins_q + ONE;
          if (halt_hit) begin
            state_d = DONE;
          end else if (wd_hit) begin
            state_d = DONE;
            to_d    = 1'b1;
          end
        end
      end
      DONE: begin
        Done = 1'b1;
        if (Start) state_d = ARM;
      end
      default: state_d = IDLE;
    endcase
    // Counters read zero for the whole of ARM, from the entry edge on
    if (state_d == ARM) begin
      cyc_d = '0;
      ins_d = '0;
      to_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      ins_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
      to_q    <= to_d;
    end
  end

  assign CycleCnt = cyc_q;
  assign InstrCnt = ins_q;
  assign Timeout  = to_q;

endmodule
